// File: rtl/rto_pkg.sv
// rto_pkg: shared types and constants for the real-time output channel.
// Optional error counters are enabled by defining RTO_ERR_COUNT_EN.
package rto_pkg;

    localparam int RTO_TS_W   = 64;
    localparam int RTO_DATA_W = 64;

    localparam int LATE_DROP = 0;
    localparam int LATE_EXEC = 1;

    // Default-width channel entry; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [RTO_TS_W-1:0]   ts;
        logic [RTO_DATA_W-1:0] payload;
    } entry_t;

    typedef enum logic {
        RTO_IDLE = 1'b0,
        RTO_RUN  = 1'b1
    } rto_state_e;

endpackage

// File: rtl/rto_sync_fifo.sv
// rto_sync_fifo: first-word-fall-through FIFO with registered level,
// full (level >= FULL_THRESH) and empty flags.
module rto_sync_fifo #(
    parameter  int EW          = 128,
    parameter  int DEPTH       = 8192,
    parameter  int FULL_THRESH = 8100,
    localparam int AW          = $clog2(DEPTH),
    localparam int LW          = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          srst,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] din,
    output logic [EW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push && !full_q && !srst;
    assign do_pop  = pop && !empty_q && !srst;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        if (srst) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end
        full_d  = (level_d >= LW'(FULL_THRESH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    assign dout  = mem[rd_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/rto_timed_fifo.sv
// rto_timed_fifo: releases buffered {ts,payload} entries when counter reaches ts.
// Define RTO_ERR_COUNT_EN to add saturating err_ts_cnt / err_ovf_cnt outputs.
module rto_timed_fifo
    import rto_pkg::*;
#(
    parameter  int TS_W        = RTO_TS_W,
    parameter  int DATA_W      = RTO_DATA_W,
    parameter  int DEPTH       = 8192,
    parameter  int FULL_THRESH = 8100,
    parameter  int LATE_POLICY = LATE_DROP,
    localparam int EW          = TS_W + DATA_W,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            auto_start,
    input  logic            flush,
    input  logic            write,
    input  logic [EW-1:0]   fifo_din,
    input  logic [TS_W-1:0] counter,
    output logic [EW-1:0]   rto_out,
    output logic            rto_valid,
    output logic            rto_late,
    output logic            timestamp_error,
    output logic [EW-1:0]   timestamp_error_data,
    output logic            overflow_error,
    output logic [EW-1:0]   overflow_error_data,
    output logic            full,
    output logic            empty,
    output logic [LW-1:0]   level
`ifdef RTO_ERR_COUNT_EN
    ,
    output logic [31:0]     err_ts_cnt,
    output logic [31:0]     err_ovf_cnt
`endif
);

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] payload;
    } head_t;

    localparam bit EXEC = (LATE_POLICY == LATE_EXEC);

    rto_state_e    state_q, state_d;
    logic [EW-1:0] head_raw;
    head_t         head;
    logic          push, pop, late, rel, ts_hit, ovf_hit;

    logic          valid_q, late_q, tserr_q, ovf_q;
    logic [EW-1:0] out_q, tserr_data_q, ovf_data_q;

    assign push = write && !full && !flush;
    assign head = head_t'(head_raw);
    assign late = (head.ts < counter);

    rto_sync_fifo #(
        .EW          (EW),
        .DEPTH       (DEPTH),
        .FULL_THRESH (FULL_THRESH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .srst  (flush),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= RTO_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RTO_IDLE: if (auto_start && !empty) state_d = RTO_RUN;
            RTO_RUN:  if (!auto_start || empty) state_d = RTO_IDLE;
        endcase
        if (flush) state_d = RTO_IDLE;
    end

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            RTO_IDLE: pop = 1'b0;
            RTO_RUN:  pop = auto_start && !empty && !flush &&
                            (head.ts <= counter);
        endcase
    end

    assign rel     = pop && (!late || EXEC);
    assign ts_hit  = pop && late;
    assign ovf_hit = write && full && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            late_q       <= 1'b0;
            tserr_q      <= 1'b0;
            ovf_q        <= 1'b0;
            out_q        <= '0;
            tserr_data_q <= '0;
            ovf_data_q   <= '0;
        end else begin
            valid_q <= rel;
            late_q  <= rel && late;
            tserr_q <= ts_hit;
            ovf_q   <= ovf_hit;
            if (rel)     out_q        <= head_raw;
            if (ts_hit)  tserr_data_q <= head_raw;
            if (ovf_hit) ovf_data_q   <= fifo_din;
        end
    end

    assign rto_out              = out_q;
    assign rto_valid            = valid_q;
    assign rto_late             = late_q;
    assign timestamp_error      = tserr_q;
    assign timestamp_error_data = tserr_data_q;
    assign overflow_error       = ovf_q;
    assign overflow_error_data  = ovf_data_q;

`ifdef RTO_ERR_COUNT_EN
    logic [31:0] ts_cnt_q, ovf_cnt_q;

    // Counted on the same edge that raises the pulse; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_cnt_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (ts_hit && ts_cnt_q != '1)   ts_cnt_q  <= ts_cnt_q + 32'd1;
            if (ovf_hit && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 32'd1;
        end
    end

    assign err_ts_cnt  = ts_cnt_q;
    assign err_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rto_timed_fifo.sv
// tb_rto_timed_fifo: directed bench, one drop-policy and one exec-policy
// instance on shared inputs, checked every cycle against a queue model.
module tb_rto_timed_fifo;

    localparam int TS_W  = 16;
    localparam int DW    = 16;
    localparam int EW    = 32;
    localparam int DEPTH = 16;
    localparam int FT    = 12;
    localparam int LW    = 5;

    logic            clk;
    logic            reset;
    logic            auto_start;
    logic            flush;
    logic            write;
    logic [EW-1:0]   fifo_din;
    logic [TS_W-1:0] counter;

    logic [EW-1:0] o0_out, o0_tsd, o0_ovd, o1_out, o1_tsd, o1_ovd;
    logic          o0_v, o0_l, o0_tse, o0_ovf, o0_full, o0_empty;
    logic          o1_v, o1_l, o1_tse, o1_ovf, o1_full, o1_empty;
    logic [LW-1:0] o0_level, o1_level;
`ifdef RTO_ERR_COUNT_EN
    logic [31:0]   c0_ts, c0_ovf, c1_ts, c1_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    rto_timed_fifo #(
        .TS_W(TS_W), .DATA_W(DW), .DEPTH(DEPTH),
        .FULL_THRESH(FT), .LATE_POLICY(0)
    ) u0 (
        .clk(clk), .reset(reset), .auto_start(auto_start),
        .flush(flush), .write(write), .fifo_din(fifo_din),
        .counter(counter), .rto_out(o0_out), .rto_valid(o0_v),
        .rto_late(o0_l), .timestamp_error(o0_tse),
        .timestamp_error_data(o0_tsd), .overflow_error(o0_ovf),
        .overflow_error_data(o0_ovd), .full(o0_full),
        .empty(o0_empty), .level(o0_level)
`ifdef RTO_ERR_COUNT_EN
        , .err_ts_cnt(c0_ts), .err_ovf_cnt(c0_ovf)
`endif
    );

    rto_timed_fifo #(
        .TS_W(TS_W), .DATA_W(DW), .DEPTH(DEPTH),
        .FULL_THRESH(FT), .LATE_POLICY(1)
    ) u1 (
        .clk(clk), .reset(reset), .auto_start(auto_start),
        .flush(flush), .write(write), .fifo_din(fifo_din),
        .counter(counter), .rto_out(o1_out), .rto_valid(o1_v),
        .rto_late(o1_l), .timestamp_error(o1_tse),
        .timestamp_error_data(o1_tsd), .overflow_error(o1_ovf),
        .overflow_error_data(o1_ovd), .full(o1_full),
        .empty(o1_empty), .level(o1_level)
`ifdef RTO_ERR_COUNT_EN
        , .err_ts_cnt(c1_ts), .err_ovf_cnt(c1_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Model: entries as a queue; releases follow the timestamp rules directly.
    logic [EW-1:0]   q[$];
    bit              m_run;
    bit              emp, ful, mpop, mlate, acc;
    logic [TS_W-1:0] hts;
    logic [EW-1:0]   e_out0, e_out1, e_tsd, e_ovd;
    bit              e_v0, e_v1, e_l1, e_tse, e_ovf;
    logic [31:0]     e_tsc, e_ovc;

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_run  = 0;
            e_out0 = '0; e_out1 = '0; e_tsd = '0; e_ovd = '0;
            e_v0 = 0; e_v1 = 0; e_l1 = 0; e_tse = 0; e_ovf = 0;
            e_tsc = '0; e_ovc = '0;
        end else begin
            emp   = (q.size() == 0);
            ful   = (q.size() >= FT);
            hts   = emp ? '0 : q[0][EW-1:DW];
            mpop  = m_run && auto_start && !emp && !flush && hts <= counter;
            mlate = mpop && hts < counter;
            e_v0  = mpop && !mlate;
            e_v1  = mpop;
            e_l1  = mlate;
            e_tse = mlate;
            if (mpop && !mlate) e_out0 = q[0];
            if (mpop)           e_out1 = q[0];
            if (mlate)          e_tsd  = q[0];
            e_ovf = write && ful && !flush;
            if (e_ovf) e_ovd = fifo_din;
            if (mlate && e_tsc != '1) e_tsc++;
            if (e_ovf && e_ovc != '1) e_ovc++;
            acc   = write && !ful && !flush;
            m_run = auto_start && !emp && !flush;
            if (flush) q.delete();
            else begin
                if (mpop) void'(q.pop_front());
                if (acc)  q.push_back(fifo_din);
            end
        end
        #1;
        chk("valid0", o0_v, e_v0);
        chk("valid1", o1_v, e_v1);
        chk("late0", o0_l, 1'b0);
        chk("late1", o1_l, e_l1);
        chk("out0", o0_out, e_out0);
        chk("out1", o1_out, e_out1);
        chk("tserr0", o0_tse, e_tse);
        chk("tserr1", o1_tse, e_tse);
        chk("tsdata0", o0_tsd, e_tsd);
        chk("tsdata1", o1_tsd, e_tsd);
        chk("ovf0", o0_ovf, e_ovf);
        chk("ovf1", o1_ovf, e_ovf);
        chk("ovdata0", o0_ovd, e_ovd);
        chk("ovdata1", o1_ovd, e_ovd);
        chk("level0", o0_level, q.size());
        chk("level1", o1_level, q.size());
        chk("full0", o0_full, q.size() >= FT);
        chk("empty0", o0_empty, q.size() == 0);
        chk("empty1", o1_empty, q.size() == 0);
`ifdef RTO_ERR_COUNT_EN
        chk("tscnt0", c0_ts, e_tsc);
        chk("ovcnt0", c0_ovf, e_ovc);
        chk("tscnt1", c1_ts, e_tsc);
        chk("ovcnt1", c1_ovf, e_ovc);
`endif
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put(input logic [15:0] ts, input logic [15:0] pl);
        write    = 1'b1;
        fifo_din = {ts, pl};
        step();
        write    = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; auto_start = 1'b0; flush = 1'b0;
        write = 1'b0; fifo_din = '0; counter = '0;
        repeat (2) step();
        reset = 1'b1;

        // 1: reset empties a partly filled FIFO
        for (int i = 0; i < 3; i++) put(16'(10 + i), 16'(i));
        chk("t1_level_pre", o0_level, 3);
        reset = 1'b0;
        step();
        chk("t1_empty", o0_empty, 1);
        chk("t1_level", o0_level, 0);
        chk("t1_valid", o0_v, 0);
        chk("t1_tserr", o0_tse, 0);
        chk("t1_ovf", o0_ovf, 0);
        reset = 1'b1;

        // 2: exact match releases one cycle after counter==ts
        counter = 16'd90;
        put(16'd100, 16'h000A);
        auto_start = 1'b1;
        for (int c = 90; c <= 100; c++) begin
            counter = 16'(c);
            step();
            chk("t2_pulse", o0_v, c == 100);
        end
        chk("t2_out0", o0_out, 32'h0064_000A);
        chk("t2_out1", o1_out, 32'h0064_000A);
        chk("t2_late1", o1_l, 0);
        counter = 16'd101;
        step();
        chk("t2_one_shot", o0_v, 0);

        // 3: late entry, drop vs exec policy
        counter = 16'd50;
        put(16'd5, 16'h0055);
        step();
        step();
        chk("t3_tserr", o0_tse, 1);
        chk("t3_tsdata", o0_tsd, 32'h0005_0055);
        chk("t3_valid0", o0_v, 0);
        chk("t3_out0_hold", o0_out, 32'h0064_000A);
        chk("t3_valid1", o1_v, 1);
        chk("t3_late1", o1_l, 1);
        chk("t3_out1", o1_out, 32'h0005_0055);
        chk("t3_empty", o0_empty, 1);

        // 4: overflow at FULL_THRESH
        auto_start = 1'b0;
        for (int i = 0; i < 13; i++) put(16'(200 + i), 16'(16'hB0 + i));
        chk("t4_level", o0_level, 12);
        chk("t4_full", o0_full, 1);
        chk("t4_ovf", o0_ovf, 1);
        chk("t4_ovdata", o0_ovd, 32'h00D4_00BC);
        step();
        chk("t4_ovf_once", o0_ovf, 0);

        // 5: hold with ts==counter, then flush with a write
        counter = 16'd200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold", o0_v, 0);
            chk("t5_hold_lvl", o0_level, 12);
        end
        flush    = 1'b1;
        write    = 1'b1;
        fifo_din = 32'h012C_0077;
        step();
        flush = 1'b0;
        write = 1'b0;
        chk("t5_flush_lvl", o0_level, 0);
        chk("t5_flush_emp", o0_empty, 1);
        chk("t5_no_ovf", o0_ovf, 0);
        chk("t5_ovdata_kept", o0_ovd, 32'h00D4_00BC);
        step();
        chk("t5_write_dropped", o0_level, 0);

        // 6: three late entries and two overflows after reset
        pulse_reset();
        counter    = 16'd50;
        auto_start = 1'b1;
        for (int i = 1; i <= 3; i++) put(16'(i), 16'(16'hE0 + i));
        repeat (6) step();
        chk("t6_drained", o0_empty, 1);
        chk("t6_tsdata", o0_tsd, 32'h0003_00E3);
        auto_start = 1'b0;
        for (int i = 0; i < 14; i++) put(16'(500 + i), 16'(i));
        step();
`ifdef RTO_ERR_COUNT_EN
        chk("t6_tscnt", c0_ts, 3);
        chk("t6_ovcnt", c0_ovf, 2);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("t6_flush_lvl", o0_level, 0);
`ifdef RTO_ERR_COUNT_EN
        chk("t6_tscnt_kept", c0_ts, 3);
        chk("t6_ovcnt_kept", c0_ovf, 2);
`endif

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
